// File: rtl/regfile_mp_pkg.sv
// Shared widths and types for the multi-port register file and its scoreboard.
package regfile_mp_pkg;

  // Default geometry of the rv32ima integer register file.
  localparam int RF_DATA_W = 32;
  localparam int RF_REG_W  = 5;

  // Architectural word and register address at the default geometry.
  typedef logic [RF_DATA_W-1:0] word_t;
  typedef logic [RF_REG_W-1:0]  regaddr_t;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register busy scoreboard: issue reserves a destination, writeback clears it.
module rf_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int REG_W    = RF_REG_W,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [NUM_WR-1:0]       wen,
  input  logic [NUM_WR*REG_W-1:0] wsel,
  input  logic                    rsv_en,
  input  logic [REG_W-1:0]        rsv_sel,
  output logic [2**REG_W-1:0]     busy,
  output logic [2**REG_W-1:0]     wr_hit,
  output logic                    rsv_hazard
);

  localparam int REG_COUNT = 2**REG_W;
  typedef logic [NUM_WR-1:0][REG_W-1:0] wraddr_vec_t;

  wraddr_vec_t          w_wsel;
  logic [REG_COUNT-1:0] r_busy;
  logic [REG_COUNT-1:0] w_busy_nxt;
  logic [REG_COUNT-1:0] w_wr_hit;
  logic                 w_hazard;
  logic                 w_accept;

  assign w_wsel     = wsel;
  assign busy       = r_busy;
  assign wr_hit     = w_wr_hit;
  assign rsv_hazard = w_hazard;

  // True when the address is the hard-wired zero register.
  function automatic logic is_hw_zero(input logic [REG_W-1:0] a);
    return (ZERO_REG != 0) && (a == {REG_W{1'b0}});
  endfunction

  // Decode which registers are written by any port this cycle.
  always_comb begin
    w_wr_hit = {REG_COUNT{1'b0}};
    for (int j = 0; j < NUM_WR; j++) begin
      if (wen[j]) begin
        w_wr_hit[w_wsel[j]] = 1'b1;
      end else begin
        w_wr_hit = w_wr_hit;
      end
    end
    if (ZERO_REG != 0) begin
      w_wr_hit[0] = 1'b0;
    end else begin
      w_wr_hit = w_wr_hit;
    end
  end

  // WAW hazard: destination still pending and not retired this cycle.
  always_comb begin
    w_hazard = rsv_en && !is_hw_zero(rsv_sel) && r_busy[rsv_sel] && !w_wr_hit[rsv_sel];
    w_accept = rsv_en && !is_hw_zero(rsv_sel) && !w_hazard;
  end

  // Next busy vector: an accepted reservation beats a same-cycle clear.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int r = 0; r < REG_COUNT; r++) begin
      if (w_accept && (rsv_sel == REG_W'(r))) begin
        w_busy_nxt[r] = 1'b1;
      end else if (w_wr_hit[r]) begin
        w_busy_nxt[r] = 1'b0;
      end else begin
        w_busy_nxt[r] = r_busy[r];
      end
    end
  end

  // Busy bit register with asynchronous clear.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_busy <= {REG_COUNT{1'b0}};
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with optional write-to-read bypass and busy scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int REG_W    = RF_REG_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [NUM_RD*REG_W-1:0]  rsel,
  output logic [NUM_RD*DATA_W-1:0] rdat,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic [NUM_WR-1:0]        wen,
  input  logic [NUM_WR*REG_W-1:0]  wsel,
  input  logic [NUM_WR*DATA_W-1:0] wdat,
  input  logic                     rsv_en,
  input  logic [REG_W-1:0]         rsv_sel,
  output logic                     rsv_hazard
);

  localparam int REG_COUNT = 2**REG_W;
  typedef logic [NUM_RD-1:0][REG_W-1:0]  rdaddr_vec_t;
  typedef logic [NUM_RD-1:0][DATA_W-1:0] rddata_vec_t;
  typedef logic [NUM_WR-1:0][REG_W-1:0]  wraddr_vec_t;
  typedef logic [NUM_WR-1:0][DATA_W-1:0] wrdata_vec_t;

  rdaddr_vec_t          w_rsel;
  rddata_vec_t          w_rdat;
  wraddr_vec_t          w_wsel;
  wrdata_vec_t          w_wdat;
  logic [NUM_RD-1:0]    w_rbusy;
  logic [REG_COUNT-1:0] w_busy;
  logic [REG_COUNT-1:0] w_wr_hit;
  logic [DATA_W-1:0]    r_mem [REG_COUNT];

  assign w_rsel = rsel;
  assign w_wsel = wsel;
  assign w_wdat = wdat;
  assign rdat   = w_rdat;
  assign rbusy  = w_rbusy;

  // True when the address is the hard-wired zero register.
  function automatic logic is_hw_zero(input logic [REG_W-1:0] a);
    return (ZERO_REG != 0) && (a == {REG_W{1'b0}});
  endfunction

  rf_scoreboard #(
    .REG_W   (REG_W),
    .NUM_WR  (NUM_WR),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .nrst      (nrst),
    .wen       (wen),
    .wsel      (wsel),
    .rsv_en    (rsv_en),
    .rsv_sel   (rsv_sel),
    .busy      (w_busy),
    .wr_hit    (w_wr_hit),
    .rsv_hazard(rsv_hazard)
  );

  // Data array: later ports override earlier ones on an address collision.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        r_mem[r] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wen[j] && !is_hw_zero(w_wsel[j])) begin
          r_mem[w_wsel[j]] <= w_wdat[j];
        end
      end
    end
  end

  // Read ports: stored value, optionally overridden by the highest same-cycle writer.
  always_comb begin
    w_rdat  = {(NUM_RD*DATA_W){1'b0}};
    w_rbusy = {NUM_RD{1'b0}};
    for (int i = 0; i < NUM_RD; i++) begin
      w_rdat[i]  = r_mem[w_rsel[i]];
      w_rbusy[i] = w_busy[w_rsel[i]];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WR; j++) begin
          if (wen[j] && (w_wsel[j] == w_rsel[i]) && !is_hw_zero(w_rsel[i])) begin
            w_rdat[i] = w_wdat[j];
          end else begin
            w_rdat[i] = w_rdat[i];
          end
        end
        // The producer retiring now makes the operand ready alongside its data.
        w_rbusy[i] = w_busy[w_rsel[i]] & ~w_wr_hit[w_rsel[i]];
      end else begin
        w_rbusy[i] = w_busy[w_rsel[i]];
      end
      if (is_hw_zero(w_rsel[i])) begin
        w_rdat[i] = {DATA_W{1'b0}};
      end else begin
        w_rdat[i] = w_rdat[i];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: bypassing and non-bypassing instances share stimulus.
module tb_regfile_mp;

  logic             clk;
  logic             nrst;
  logic [1:0][4:0]  rsel;
  logic [1:0][31:0] rdat;
  logic [1:0]       rbusy;
  logic [1:0][31:0] nb_rdat;
  logic [1:0]       nb_rbusy;
  logic             nb_hazard;
  logic [1:0]       wen;
  logic [1:0][4:0]  wsel;
  logic [1:0][31:0] wdat;
  logic             rsv_en;
  logic [4:0]       rsv_sel;
  logic             rsv_hazard;

  typedef struct {
    logic [31:0] d0;   // bypassing data
    logic        b0;   // bypassing busy
    logic [31:0] n0;   // stored-only data
    logic        nb0;  // raw busy
    logic        h;    // hazard
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp;
  int   n_err;

  regfile_mp u_dut (
    .clk(clk), .nrst(nrst), .rsel(rsel), .rdat(rdat), .rbusy(rbusy),
    .wen(wen), .wsel(wsel), .wdat(wdat),
    .rsv_en(rsv_en), .rsv_sel(rsv_sel), .rsv_hazard(rsv_hazard)
  );

  regfile_mp #(.BYPASS(0)) u_nb (
    .clk(clk), .nrst(nrst), .rsel(rsel), .rdat(nb_rdat), .rbusy(nb_rbusy),
    .wen(wen), .wsel(wsel), .wdat(wdat),
    .rsv_en(rsv_en), .rsv_sel(rsv_sel), .rsv_hazard(nb_hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    wen     = 2'b00;
    wsel    = '{5'd0, 5'd0};
    wdat    = '{32'd0, 32'd0};
    rsv_en  = 1'b0;
    rsv_sel = 5'd0;
  endtask

  task automatic set_rd(input logic [4:0] a);
    rsel[0] = a;
    rsel[1] = a;
  endtask

  task automatic test_reset();
    logic [4:0] addrs [3];
    addrs = '{5'd0, 5'd5, 5'd31};
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      idle();
      set_rd(addrs[s]);
      rsv_en  = 1'b1;
      rsv_sel = 5'd0;
      exp_q.push_back('{32'd0, 1'b0, 32'd0, 1'b0, 1'b0});
      #2;
      e = exp_q.pop_front();
      n_cmp += 6;
      if (rdat[0] !== e.d0) begin n_err++; $display("FAIL reset s%0d rdat0 got %h want %h", s, rdat[0], e.d0); end
      if (rdat[1] !== e.d0) begin n_err++; $display("FAIL reset s%0d rdat1 got %h want %h", s, rdat[1], e.d0); end
      if (rbusy[0] !== e.b0) begin n_err++; $display("FAIL reset s%0d rbusy0 got %b want %b", s, rbusy[0], e.b0); end
      if (rsv_hazard !== e.h) begin n_err++; $display("FAIL reset s%0d hazard got %b want %b", s, rsv_hazard, e.h); end
      if (nb_rdat[0] !== e.n0) begin n_err++; $display("FAIL reset s%0d nb_rdat0 got %h want %h", s, nb_rdat[0], e.n0); end
      if (nb_rbusy[0] !== e.nb0) begin n_err++; $display("FAIL reset s%0d nb_rbusy0 got %b want %b", s, nb_rbusy[0], e.nb0); end
    end
  endtask

  task automatic test_write_collision();
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      idle();
      set_rd(5'd5);
      if (s == 0) begin
        wen  = 2'b11;
        wsel = '{5'd5, 5'd5};
        wdat = '{32'h12345678, 32'hDEADBEEF};
        exp_q.push_back('{32'h12345678, 1'b0, 32'd0, 1'b0, 1'b0});
      end else begin
        exp_q.push_back('{32'h12345678, 1'b0, 32'h12345678, 1'b0, 1'b0});
      end
      #2;
      e = exp_q.pop_front();
      n_cmp += 5;
      if (rdat[0] !== e.d0) begin n_err++; $display("FAIL collision s%0d rdat0 got %h want %h", s, rdat[0], e.d0); end
      if (rdat[1] !== e.d0) begin n_err++; $display("FAIL collision s%0d rdat1 got %h want %h", s, rdat[1], e.d0); end
      if (rbusy[0] !== e.b0) begin n_err++; $display("FAIL collision s%0d rbusy0 got %b want %b", s, rbusy[0], e.b0); end
      if (nb_rdat[0] !== e.n0) begin n_err++; $display("FAIL collision s%0d nb_rdat0 got %h want %h", s, nb_rdat[0], e.n0); end
      if (rsv_hazard !== e.h) begin n_err++; $display("FAIL collision s%0d hazard got %b want %b", s, rsv_hazard, e.h); end
    end
  endtask

  task automatic test_zero_reg();
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      idle();
      set_rd(5'd0);
      if (s == 0) begin
        wen     = 2'b01;
        wsel[0] = 5'd0;
        wdat[0] = 32'hFFFFFFFF;
      end else if (s == 1) begin
        rsv_en  = 1'b1;
        rsv_sel = 5'd0;
      end
      exp_q.push_back('{32'd0, 1'b0, 32'd0, 1'b0, 1'b0});
      #2;
      e = exp_q.pop_front();
      n_cmp += 6;
      if (rdat[0] !== e.d0) begin n_err++; $display("FAIL zero s%0d rdat0 got %h want %h", s, rdat[0], e.d0); end
      if (rbusy[0] !== e.b0) begin n_err++; $display("FAIL zero s%0d rbusy0 got %b want %b", s, rbusy[0], e.b0); end
      if (nb_rdat[0] !== e.n0) begin n_err++; $display("FAIL zero s%0d nb_rdat0 got %h want %h", s, nb_rdat[0], e.n0); end
      if (nb_rbusy[0] !== e.nb0) begin n_err++; $display("FAIL zero s%0d nb_rbusy0 got %b want %b", s, nb_rbusy[0], e.nb0); end
      if (rsv_hazard !== e.h) begin n_err++; $display("FAIL zero s%0d hazard got %b want %b", s, rsv_hazard, e.h); end
      if (nb_hazard !== e.h) begin n_err++; $display("FAIL zero s%0d nb_hazard got %b want %b", s, nb_hazard, e.h); end
    end
  endtask

  task automatic test_reserve_hazard();
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      idle();
      set_rd(5'd7);
      case (s)
        0: begin
          rsv_en = 1'b1; rsv_sel = 5'd7;
          exp_q.push_back('{32'd0, 1'b0, 32'd0, 1'b0, 1'b0});
        end
        1: begin
          rsv_en = 1'b1; rsv_sel = 5'd7;
          exp_q.push_back('{32'd0, 1'b1, 32'd0, 1'b1, 1'b1});
        end
        2: begin
          wen = 2'b10; wsel[1] = 5'd7; wdat[1] = 32'hA5A5A5A5;
          exp_q.push_back('{32'hA5A5A5A5, 1'b0, 32'd0, 1'b1, 1'b0});
        end
        default: begin
          exp_q.push_back('{32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0});
        end
      endcase
      #2;
      e = exp_q.pop_front();
      n_cmp += 6;
      if (rdat[0] !== e.d0) begin n_err++; $display("FAIL waw s%0d rdat0 got %h want %h", s, rdat[0], e.d0); end
      if (rbusy[0] !== e.b0) begin n_err++; $display("FAIL waw s%0d rbusy0 got %b want %b", s, rbusy[0], e.b0); end
      if (nb_rdat[0] !== e.n0) begin n_err++; $display("FAIL waw s%0d nb_rdat0 got %h want %h", s, nb_rdat[0], e.n0); end
      if (nb_rbusy[0] !== e.nb0) begin n_err++; $display("FAIL waw s%0d nb_rbusy0 got %b want %b", s, nb_rbusy[0], e.nb0); end
      if (rsv_hazard !== e.h) begin n_err++; $display("FAIL waw s%0d hazard got %b want %b", s, rsv_hazard, e.h); end
      if (nb_hazard !== e.h) begin n_err++; $display("FAIL waw s%0d nb_hazard got %b want %b", s, nb_hazard, e.h); end
    end
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      idle();
      set_rd(5'd9);
      case (s)
        0: begin
          rsv_en = 1'b1; rsv_sel = 5'd9;
          wen = 2'b01; wsel[0] = 5'd9; wdat[0] = 32'h00000011;
          exp_q.push_back('{32'h00000011, 1'b0, 32'd0, 1'b0, 1'b0});
        end
        1: exp_q.push_back('{32'h00000011, 1'b1, 32'h00000011, 1'b1, 1'b0});
        2: begin
          rsv_en = 1'b1; rsv_sel = 5'd9;
          wen = 2'b10; wsel[1] = 5'd9; wdat[1] = 32'h00000022;
          exp_q.push_back('{32'h00000022, 1'b0, 32'h00000011, 1'b1, 1'b0});
        end
        default: exp_q.push_back('{32'h00000022, 1'b1, 32'h00000022, 1'b1, 1'b0});
      endcase
      #2;
      e = exp_q.pop_front();
      n_cmp += 5;
      if (rdat[0] !== e.d0) begin n_err++; $display("FAIL rsvwr s%0d rdat0 got %h want %h", s, rdat[0], e.d0); end
      if (rbusy[0] !== e.b0) begin n_err++; $display("FAIL rsvwr s%0d rbusy0 got %b want %b", s, rbusy[0], e.b0); end
      if (nb_rdat[0] !== e.n0) begin n_err++; $display("FAIL rsvwr s%0d nb_rdat0 got %h want %h", s, nb_rdat[0], e.n0); end
      if (nb_rbusy[0] !== e.nb0) begin n_err++; $display("FAIL rsvwr s%0d nb_rbusy0 got %b want %b", s, nb_rbusy[0], e.nb0); end
      if (rsv_hazard !== e.h) begin n_err++; $display("FAIL rsvwr s%0d hazard got %b want %b", s, rsv_hazard, e.h); end
    end
  endtask

  task automatic test_async_reset();
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      idle();
      case (s)
        0: begin
          set_rd(5'd3);
          wen = 2'b01; wsel[0] = 5'd3; wdat[0] = 32'h00000055;
          rsv_en = 1'b1; rsv_sel = 5'd4;
          exp_q.push_back('{32'h00000055, 1'b0, 32'd0, 1'b0, 1'b0});
        end
        1: begin
          set_rd(5'd3);
          exp_q.push_back('{32'h00000055, 1'b0, 32'h00000055, 1'b0, 1'b0});
        end
        2: begin
          set_rd(5'd4);
          exp_q.push_back('{32'd0, 1'b1, 32'd0, 1'b1, 1'b0});
        end
        3: begin
          set_rd(5'd3);
          #1 nrst = 1'b0;
          exp_q.push_back('{32'd0, 1'b0, 32'd0, 1'b0, 1'b0});
        end
        default: begin
          set_rd(5'd4);
          exp_q.push_back('{32'd0, 1'b0, 32'd0, 1'b0, 1'b0});
        end
      endcase
      #2;
      e = exp_q.pop_front();
      n_cmp += 4;
      if (rdat[0] !== e.d0) begin n_err++; $display("FAIL arst s%0d rdat0 got %h want %h", s, rdat[0], e.d0); end
      if (rbusy[0] !== e.b0) begin n_err++; $display("FAIL arst s%0d rbusy0 got %b want %b", s, rbusy[0], e.b0); end
      if (nb_rdat[0] !== e.n0) begin n_err++; $display("FAIL arst s%0d nb_rdat0 got %h want %h", s, nb_rdat[0], e.n0); end
      if (nb_rbusy[0] !== e.nb0) begin n_err++; $display("FAIL arst s%0d nb_rbusy0 got %b want %b", s, nb_rbusy[0], e.nb0); end
    end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    nrst  = 1'b0;
    idle();
    set_rd(5'd0);
    repeat (2) @(negedge clk);
    #1 nrst = 1'b1;
    test_reset();
    test_write_collision();
    test_zero_reg();
    test_reserve_hazard();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
